eth_pcs_rx_block_lock: RTL and testbench
========================================

# eth_pcs_rx_block_lock

Parametrised 10GBASE-R receive block synchroniser and BER monitor, a single-clock successor to the fixed-threshold block-sync constants in the PCS package. It sits between the RX gearbox and the descrambler/decoder. It inspects the 2-bit sync header of every received 66-bit block and drives the gearbox slip request until header alignment is found. It then reports block lock and the high-BER condition, and keeps a saturating errored-header count for status registers.

## Interface
Parameters:
- SH_TH, 64: headers examined per test window (lock acquisition and lock maintenance).
- SH_INVAL_TH, 16: invalid headers within one SH_TH window that drop lock.
- SLIP_WAIT, 2: valid blocks ignored after each slip, so the gearbox realigns before testing.
- BER_WIN_CYC, 19531: BER window length in clock cycles (125 us at 156.25 MHz).
- BER_TH, 16: invalid headers within one BER window that set hi_ber.
- W_ERR_CNT, 6: width of the cumulative errored-header counter.

Ports:
- i_clk, input, 1: clock; all logic is on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_valid, input, 1: i_sync carries the header of a new block this cycle.
- i_sync, input, 2: sync header; 01 (SYNC_DATA) and 10 (SYNC_CTRL) are valid, 00 and 11 are invalid.
- o_slip, output, 1: one-cycle pulse requesting the gearbox to shift alignment by one bit.
- o_block_lock, output, 1: block lock status.
- o_hi_ber, output, 1: high bit-error-rate status.
- o_err_cnt, output, W_ERR_CNT: saturating count of invalid headers seen while locked.
- i_err_clr, input, 1: synchronous clear of o_err_cnt.

## Operation
- Reset values: o_slip=0, o_block_lock=0, o_hi_ber=0, o_err_cnt=0. All internal counters are 0 and the FSM is in TEST.
- Counters:
  - sh_cnt is $clog2(SH_TH+1) bits wide.
  - inv_cnt is $clog2(SH_INVAL_TH+1) bits wide.
  - wait_cnt is $clog2(SLIP_WAIT+1) bits wide.
  - Only cycles with i_valid=1 count; i_valid=0 freezes the FSM and all header counters.
- FSM states are TEST and SLIP_WAIT.
- TEST, unlocked:
  - Each valid block increments sh_cnt.
  - An invalid header produces an o_slip pulse, clears sh_cnt and inv_cnt, loads wait_cnt=SLIP_WAIT, and moves to SLIP_WAIT.
  - When sh_cnt reaches SH_TH with all headers valid, o_block_lock=1 and sh_cnt and inv_cnt clear.
- TEST, locked:
  - Each block increments sh_cnt; an invalid header also increments inv_cnt.
  - When inv_cnt reaches SH_INVAL_TH: o_block_lock=0, o_slip pulse, counters clear, go to SLIP_WAIT.
  - Otherwise, when sh_cnt reaches SH_TH: sh_cnt and inv_cnt clear and lock is kept.
  - If the header that makes inv_cnt=SH_INVAL_TH is also the SH_TH-th header, the slip/unlock path wins.
- SLIP_WAIT:
  - Each valid block decrements wait_cnt; headers are ignored.
  - At 0, return to TEST, unlocked.
  - With SLIP_WAIT=0, the FSM returns to TEST on the next cycle.
- BER monitor, active only while o_block_lock=1:
  - win_cnt counts every clock cycle and wraps after BER_WIN_CYC-1.
  - ber_cnt counts invalid headers within the window and saturates at BER_TH.
  - When ber_cnt reaches BER_TH, o_hi_ber=1 on the next cycle.
  - At window end: if ber_cnt<BER_TH, o_hi_ber=0. ber_cnt clears in either case.
  - While o_block_lock=0: win_cnt, ber_cnt and o_hi_ber are all held at 0.
- o_err_cnt:
  - Increments on each invalid header while locked and saturates at 2^W_ERR_CNT-1.
  - i_err_clr has priority; clear and increment in the same cycle yields 0.
- Parameter checks at elaboration: SH_INVAL_TH<=SH_TH, BER_TH>=1, BER_WIN_CYC>=2.

## Timing
- All outputs are registered.
- o_slip is high exactly for the cycle after the deciding header is sampled. At most one pulse is issued per SLIP_WAIT+1 valid blocks.
- o_block_lock changes the cycle after the SH_TH-th header (acquire) or the SH_INVAL_TH-th invalid header (drop).
- o_hi_ber rises one cycle after the BER_TH-th invalid header in a window. It falls one cycle after a window end with ber_cnt<BER_TH.
- Asserting i_rst_n=0 mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge. The first valid block after release starts a fresh TEST window.

## Test plan
- 64 consecutive valid headers after reset -> o_block_lock=1 one cycle after the 64th; o_slip never asserted.
- Header 00 on block 10 of acquisition -> o_slip pulse one cycle later; the next 2 blocks are ignored; lock occurs 64 valid blocks after that.
- Locked link, 15 invalid headers in one 64-block window -> lock held, o_err_cnt=15. 16 invalid headers in the next window -> o_block_lock=0 and an o_slip pulse. A 16th invalid header landing on the 64th block also unlocks.
- Locked link, 16 invalid headers spread within 19531 cycles (inv_cnt kept below 16 per window) -> o_hi_ber=1. A following clean window -> o_hi_ber=0 at window end.
- 70 invalid headers while locked with W_ERR_CNT=6 -> o_err_cnt saturates at 63. i_err_clr together with an invalid header -> 0.
- i_valid toggling 1-of-3 cycles, plus reset asserted mid-acquisition -> counters advance only on valid blocks; all outputs go to 0 immediately on reset.

Source files
------------

// File: rtl/eth_pcs_rx_block_lock.sv
// 10GBASE-R RX block synchroniser with BER monitor and saturating errored-header counter.
// All outputs registered (one cycle after the deciding header); no backpressure, i_valid=0 only stalls header counting.
module eth_pcs_rx_block_lock #(
  parameter int SH_TH       = 64,
  parameter int SH_INVAL_TH = 16,
  parameter int SLIP_WAIT   = 2,
  parameter int BER_WIN_CYC = 19531,
  parameter int BER_TH      = 16,
  parameter int W_ERR_CNT   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_sync,
  input  logic                 i_err_clr,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic                 o_hi_ber,
  output logic [W_ERR_CNT-1:0] o_err_cnt
);

  localparam int SHW  = $clog2(SH_TH + 1);
  localparam int IVW  = $clog2(SH_INVAL_TH + 1);
  localparam int WTW  = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam int WINW = $clog2(BER_WIN_CYC);
  localparam int BERW = $clog2(BER_TH + 1);

  if (SH_INVAL_TH > SH_TH) begin : g_chk_inval
    $error("SH_INVAL_TH must not exceed SH_TH");
  end
  if (BER_TH < 1) begin : g_chk_ber_th
    $error("BER_TH must be at least 1");
  end
  if (BER_WIN_CYC < 2) begin : g_chk_ber_win
    $error("BER_WIN_CYC must be at least 2");
  end

  typedef enum logic {ST_TEST, ST_SLIP_WAIT} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       sh_cnt_q, sh_cnt_d;
  logic [IVW-1:0]       inv_cnt_q, inv_cnt_d;
  logic [WTW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [WINW-1:0]      win_cnt_q, win_cnt_d;
  logic [BERW-1:0]      ber_cnt_q, ber_cnt_d;
  logic [W_ERR_CNT-1:0] err_cnt_q, err_cnt_d;
  logic                 slip_q, slip_d;
  logic                 lock_q, lock_d;
  logic                 hi_ber_q, hi_ber_d;

  logic                 hdr_bad;
  logic                 bad_locked;
  logic [SHW-1:0]       sh_inc;
  logic [IVW-1:0]       inv_inc;
  logic [BERW-1:0]      ber_inc;
  logic                 win_end;

  always_comb begin
    hdr_bad    = (i_sync == 2'b00) || (i_sync == 2'b11);
    bad_locked = lock_q && i_valid && hdr_bad;
    sh_inc     = sh_cnt_q + 1'b1;
    inv_inc    = inv_cnt_q + 1'b1;
  end

  // Block-sync FSM: header windows, slip requests and lock status.
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    case (state_q)
      ST_TEST: begin
        if (i_valid) begin
          sh_cnt_d = sh_inc;
          if (!lock_q) begin
            if (hdr_bad) begin
              slip_d     = 1'b1;
              sh_cnt_d   = '0;
              inv_cnt_d  = '0;
              wait_cnt_d = WTW'(SLIP_WAIT);
              state_d    = ST_SLIP_WAIT;
            end else if (sh_inc == SHW'(SH_TH)) begin
              lock_d    = 1'b1;
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
            end
          end else begin
            if (hdr_bad) begin
              inv_cnt_d = inv_inc;
            end
            // Unlock takes precedence over a window closing on the same header.
            if (hdr_bad && (inv_inc == IVW'(SH_INVAL_TH))) begin
              lock_d     = 1'b0;
              slip_d     = 1'b1;
              sh_cnt_d   = '0;
              inv_cnt_d  = '0;
              wait_cnt_d = WTW'(SLIP_WAIT);
              state_d    = ST_SLIP_WAIT;
            end else if (sh_inc == SHW'(SH_TH)) begin
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
            end
          end
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_TEST;
        end else if (i_valid) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q == WTW'(1)) begin
            state_d = ST_TEST;
          end
        end
      end
      default: state_d = ST_TEST;
    endcase
  end

  // BER window runs only while locked; hi_ber falls together with lock.
  always_comb begin
    win_cnt_d = win_cnt_q;
    ber_cnt_d = ber_cnt_q;
    hi_ber_d  = hi_ber_q;
    win_end   = (win_cnt_q == WINW'(BER_WIN_CYC - 1));
    ber_inc   = (bad_locked && (ber_cnt_q != BERW'(BER_TH))) ? ber_cnt_q + 1'b1 : ber_cnt_q;
    if (!lock_d) begin
      win_cnt_d = '0;
      ber_cnt_d = '0;
      hi_ber_d  = 1'b0;
    end else if (lock_q) begin
      if (win_end) begin
        win_cnt_d = '0;
        ber_cnt_d = '0;
        hi_ber_d  = (ber_inc == BERW'(BER_TH));
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        ber_cnt_d = ber_inc;
        if (ber_inc == BERW'(BER_TH)) begin
          hi_ber_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_err_clr) begin
      err_cnt_d = '0;
    end else if (bad_locked && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_TEST;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      win_cnt_q  <= '0;
      ber_cnt_q  <= '0;
      err_cnt_q  <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
      hi_ber_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      win_cnt_q  <= win_cnt_d;
      ber_cnt_q  <= ber_cnt_d;
      err_cnt_q  <= err_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
      hi_ber_q   <= hi_ber_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;
  assign o_hi_ber     = hi_ber_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Directed-random bench for eth_pcs_rx_block_lock against a block-level behavioural model.
module tb_eth_pcs_rx_block_lock;
  localparam int SH_TH       = 64;
  localparam int SH_INVAL_TH = 16;
  localparam int SLIP_WAIT   = 2;
  localparam int BER_WIN_CYC = 19531;
  localparam int BER_TH      = 16;
  localparam int W_ERR_CNT   = 6;
  localparam int ERR_MAX     = (1 << W_ERR_CNT) - 1;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_valid = 1'b0;
  logic [1:0]           i_sync = 2'b01;
  logic                 i_err_clr = 1'b0;
  logic                 o_slip;
  logic                 o_block_lock;
  logic                 o_hi_ber;
  logic [W_ERR_CNT-1:0] o_err_cnt;

  int checks = 0;
  int failures = 0;
  int slips_seen = 0;

  // Reference model: counts of blocks, bad headers and cycles, kept as plain integers.
  int m_locked, m_blocks, m_bad, m_ignore, m_err, m_bcyc, m_bbad, m_hi, m_slip;

  eth_pcs_rx_block_lock #(
    .SH_TH(SH_TH), .SH_INVAL_TH(SH_INVAL_TH), .SLIP_WAIT(SLIP_WAIT),
    .BER_WIN_CYC(BER_WIN_CYC), .BER_TH(BER_TH), .W_ERR_CNT(W_ERR_CNT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_sync(i_sync),
    .i_err_clr(i_err_clr), .o_slip(o_slip), .o_block_lock(o_block_lock),
    .o_hi_ber(o_hi_ber), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_blocks = 0; m_bad = 0; m_ignore = 0;
    m_err = 0; m_bcyc = 0; m_bbad = 0; m_hi = 0; m_slip = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] s, input bit c);
    bit bad;
    int was_locked;
    bad = (s == 2'b00) || (s == 2'b11);
    was_locked = m_locked;
    m_slip = 0;
    if (v) begin
      if (m_ignore > 0) begin
        m_ignore--;
      end else if (m_locked == 0) begin
        if (bad) begin
          m_slip = 1; m_blocks = 0; m_bad = 0; m_ignore = SLIP_WAIT;
        end else begin
          m_blocks++;
          if (m_blocks == SH_TH) begin
            m_locked = 1; m_blocks = 0; m_bad = 0;
          end
        end
      end else begin
        m_blocks++;
        if (bad) m_bad++;
        if (m_bad == SH_INVAL_TH) begin
          m_locked = 0; m_slip = 1; m_blocks = 0; m_bad = 0; m_ignore = SLIP_WAIT;
        end else if (m_blocks == SH_TH) begin
          m_blocks = 0; m_bad = 0;
        end
      end
    end
    if (c) m_err = 0;
    else if (v && bad && was_locked != 0 && m_err < ERR_MAX) m_err++;
    if (m_locked == 0) begin
      m_bcyc = 0; m_bbad = 0; m_hi = 0;
    end else if (was_locked != 0) begin
      m_bcyc++;
      if (v && bad && m_bbad < BER_TH) m_bbad++;
      if (m_bcyc == BER_WIN_CYC) begin
        m_hi = (m_bbad >= BER_TH) ? 1 : 0;
        m_bbad = 0; m_bcyc = 0;
      end else if (m_bbad >= BER_TH) begin
        m_hi = 1;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] s, input bit c);
    i_valid = v; i_sync = s; i_err_clr = c;
    @(posedge i_clk);
    model_step(v, s, c);
    #1;
    if (o_slip === 1'b1) slips_seen++;
    chk("slip", o_slip, m_slip);
    chk("lock", o_block_lock, m_locked);
    chk("hi_ber", o_hi_ber, m_hi);
    chk("err_cnt", o_err_cnt, m_err);
  endtask

  // One block, sometimes preceded by an idle cycle carrying a random (ignored) header.
  task automatic blk(input logic [1:0] s, input bit c);
    if ($urandom_range(0, 3) == 0) cycle(1'b0, 2'($urandom), 1'b0);
    cycle(1'b1, s, c);
  endtask

  // n blocks with exactly k bad headers at random positions.
  task automatic mix(input int n, input int k);
    int rem;
    rem = k;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, n - i - 1) < rem) begin
        blk(bad_hdr(), 1'b0);
        rem--;
      end else begin
        blk(good_hdr(), 1'b0);
      end
    end
  endtask

  task automatic acquire(input string tag);
    for (int i = 0; i < SH_TH - 1; i++) blk(good_hdr(), 1'b0);
    chk({tag, "_pre"}, o_block_lock, 0);
    blk(good_hdr(), 1'b0);
    chk({tag, "_lock"}, o_block_lock, 1);
  endtask

  task automatic async_reset(input string tag);
    #2 i_rst_n = 1'b0;
    #1;
    chk({tag, "_slip"}, o_slip, 0);
    chk({tag, "_lock"}, o_block_lock, 0);
    chk({tag, "_hi_ber"}, o_hi_ber, 0);
    chk({tag, "_err"}, o_err_cnt, 0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_slip", o_slip, 0);
    chk("rst_lock", o_block_lock, 0);
    chk("rst_hi_ber", o_hi_ber, 0);
    chk("rst_err", o_err_cnt, 0);
    i_rst_n = 1'b1;

    // Clean acquisition.
    acquire("acq1");
    chk("acq1_no_slip", slips_seen, 0);

    // 15 bad in one window keeps lock; 16 in the next drops it.
    mix(SH_TH, SH_INVAL_TH - 1);
    chk("w15_lock", o_block_lock, 1);
    chk("w15_err", o_err_cnt, 15);
    mix(39, SH_INVAL_TH - 1);
    chk("w16_pre", o_block_lock, 1);
    blk(bad_hdr(), 1'b0);
    chk("w16_unlock", o_block_lock, 0);
    chk("w16_slip", o_slip, 1);

    // Slip-wait ignores two blocks; bad header on block 10 of acquisition slips again.
    for (int i = 0; i < SLIP_WAIT; i++) blk(bad_hdr(), 1'b0);
    for (int i = 0; i < 9; i++) blk(good_hdr(), 1'b0);
    blk(2'b00, 1'b0);
    chk("blk10_slip", o_slip, 1);
    for (int i = 0; i < SLIP_WAIT; i++) blk(bad_hdr(), 1'b0);
    acquire("acq2");

    // 16th bad header on the 64th block of the window.
    mix(SH_TH - 1, SH_INVAL_TH - 1);
    blk(bad_hdr(), 1'b0);
    chk("edge_unlock", o_block_lock, 0);
    chk("edge_slip", o_slip, 1);
    for (int i = 0; i < SLIP_WAIT; i++) blk(bad_hdr(), 1'b0);
    acquire("acq3");

    // Error counter clear, saturation and hi_ber from spread errors.
    blk(good_hdr(), 1'b1);
    chk("clr_err", o_err_cnt, 0);
    mix(SH_TH - 1, 14);
    chk("ber14_hi", o_hi_ber, 0);
    mix(SH_TH, 14);
    chk("ber28_hi", o_hi_ber, 1);
    for (int i = 0; i < 3; i++) mix(SH_TH, 14);
    chk("sat_err", o_err_cnt, ERR_MAX);
    chk("sat_lock", o_block_lock, 1);
    blk(bad_hdr(), 1'b1);
    chk("clr_vs_inc", o_err_cnt, 0);
    chk("clr_lock", o_block_lock, 1);

    // First BER window closes with >= BER_TH errors, the next one closes clean.
    for (int i = 0; i < BER_WIN_CYC; i++) cycle(1'b1, good_hdr(), 1'b0);
    chk("ber_win1_hi", o_hi_ber, 1);
    for (int i = 0; i < BER_WIN_CYC; i++) cycle(1'b1, good_hdr(), 1'b0);
    chk("ber_win2_hi", o_hi_ber, 0);
    chk("ber_win2_lock", o_block_lock, 1);
    blk(bad_hdr(), 1'b0);
    chk("pre_rst_err", o_err_cnt, 1);
    async_reset("rst_locked");

    // Sparse valid (1 of 3 cycles), reset mid-acquisition, then acquire from scratch.
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, bad_hdr(), 1'b0);
      cycle(1'b0, bad_hdr(), 1'b0);
      cycle(1'b1, good_hdr(), 1'b0);
    end
    chk("sparse_lock", o_block_lock, 0);
    async_reset("rst_acq");
    for (int i = 0; i < SH_TH; i++) begin
      cycle(1'b0, bad_hdr(), 1'b0);
      cycle(1'b0, bad_hdr(), 1'b0);
      cycle(1'b1, good_hdr(), 1'b0);
      if (i == SH_TH - 2) chk("sparse63_lock", o_block_lock, 0);
    end
    chk("sparse64_lock", o_block_lock, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
